// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: memory status codes, arbiter
// states, owner encoding and the latched request record.
package dmem_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE  = 2'b00,
        DMEM_BUSY  = 2'b01,
        DMEM_DONE  = 2'b10,
        DMEM_ERROR = 2'b11
    } mem_status_e;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    localparam logic OWN_PIPE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dmem_req_t;

    function automatic logic is_final(mem_status_e s);
        return (s == DMEM_DONE) || (s == DMEM_ERROR);
    endfunction

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection between pipeline and debug ports, with a saturating
// counter that forces a debug grant after repeated pipeline wins.
module dmem_arb_select
    import dmem_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic p0_req_i,
    input  logic p1_req_i,
    input  logic arb_en_i,
    output logic grant_o,
    output logic owner_o
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve_cnt_q;
    logic [CW-1:0] starve_cnt_d;

    always_comb begin
        grant_o = arb_en_i && (p0_req_i || p1_req_i);
        owner_o = OWN_PIPE;
        if (p1_req_i && (!p0_req_i || starve_cnt_q == LIMIT)) begin
            owner_o = OWN_DBG;
        end
    end

    // Only pipeline wins that made the debug port wait push the counter up.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_o) begin
            if (owner_o == OWN_PIPE && p1_req_i) begin
                if (starve_cnt_q != LIMIT) begin
                    starve_cnt_d = starve_cnt_q + 1'b1;
                end
            end else begin
                starve_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DataMemory port between the pipeline memory stage and the
// debug/loader port, one transaction at a time, and stalls the pipeline.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int TIMEOUT      = 255,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic [31:0] p0_rdata,
    output logic        p0_done,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic [31:0] p1_rdata,
    output logic        p1_done,
    output logic        p1_err,
    output logic        stall_m,
    output logic        mem_write_enabled,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_w_data,
    input  logic [31:0] mem_r_data,
    input  logic [1:0]  mem_status
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    arb_state_e  state_q, state_d;
    dmem_req_t   req_q, req_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic        err_q, err_d;
    logic [31:0] p0_rdata_q, p0_rdata_d;
    logic [31:0] p1_rdata_q, p1_rdata_d;

    logic        grant;
    logic        win_owner;
    mem_status_e status;
    logic        timed_out;

    assign status    = mem_status_e'(mem_status);
    assign timed_out = (to_cnt_q == TO_LAST);

    dmem_arb_select #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_select (
        .clk_i   (clk),
        .rst_i   (rst),
        .p0_req_i(p0_req),
        .p1_req_i(p1_req),
        .arb_en_i(state_q == ARB_IDLE),
        .grant_o (grant),
        .owner_o (win_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE:  if (grant) state_d = ARB_ISSUE;
            ARB_ISSUE: state_d = ARB_BUSY;
            ARB_BUSY:  if (is_final(status) || timed_out) state_d = ARB_RESP;
            ARB_RESP:  state_d = ARB_IDLE;
            default:   state_d = ARB_IDLE;
        endcase
    end

    // Latches and response capture; a completion status beats the timeout.
    always_comb begin
        req_d      = req_q;
        to_cnt_d   = to_cnt_q;
        err_d      = err_q;
        p0_rdata_d = p0_rdata_q;
        p1_rdata_d = p1_rdata_q;
        case (state_q)
            ARB_IDLE: begin
                if (grant) begin
                    req_d.owner = win_owner;
                    req_d.we    = (win_owner == OWN_DBG) ? p1_we    : p0_we;
                    req_d.addr  = (win_owner == OWN_DBG) ? p1_addr  : p0_addr;
                    req_d.wdata = (win_owner == OWN_DBG) ? p1_wdata : p0_wdata;
                end
            end
            ARB_ISSUE: to_cnt_d = '0;
            ARB_BUSY: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (status == DMEM_DONE) begin
                    err_d = 1'b0;
                    if (req_q.owner == OWN_PIPE) p0_rdata_d = mem_r_data;
                    else                         p1_rdata_d = mem_r_data;
                end else if (status == DMEM_ERROR || timed_out) begin
                    err_d = 1'b1;
                    if (req_q.owner == OWN_PIPE) p0_rdata_d = '0;
                    else                         p1_rdata_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= '0;
            to_cnt_q   <= '0;
            err_q      <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            req_q      <= req_d;
            to_cnt_q   <= to_cnt_d;
            err_q      <= err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    always_comb begin
        mem_req           = (state_q == ARB_ISSUE);
        mem_write_enabled = 1'b0;
        mem_addr          = '0;
        mem_w_data        = '0;
        if (state_q == ARB_ISSUE || state_q == ARB_BUSY) begin
            mem_write_enabled = req_q.we;
            mem_addr          = req_q.addr;
            mem_w_data        = req_q.wdata;
        end
        p0_done = (state_q == ARB_RESP) && (req_q.owner == OWN_PIPE);
        p1_done = (state_q == ARB_RESP) && (req_q.owner == OWN_DBG);
        p0_err  = p0_done && err_q;
        p1_err  = p1_done && err_q;
        stall_m = p0_req && !p0_done;
    end

    assign p0_rdata = p0_rdata_q;
    assign p1_rdata = p1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a cycle-timeline model of each transaction
// plus a reactive memory responder, checked every cycle.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    localparam int TO = 8;
    localparam int SL = 4;

    logic        clk, rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [31:0] p0_rdata, p1_rdata;
    logic        p0_done, p0_err, p1_done, p1_err, stall_m;
    logic        mem_write_enabled, mem_req;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic [1:0]  mem_status;

    dmem_arbiter #(.TIMEOUT(TO), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rdata(p0_rdata), .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rdata(p1_rdata), .p1_done(p1_done), .p1_err(p1_err),
        .stall_m(stall_m), .mem_write_enabled(mem_write_enabled), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_w_data(mem_w_data), .mem_r_data(mem_r_data),
        .mem_status(mem_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {bit port; bit we; logic [31:0] addr; logic [31:0] wdata;} txn_t;
    typedef struct {bit port; bit err; logic [31:0] rdata;} resp_t;

    txn_t  issueAt[int];
    txn_t  busyAt[int];
    resp_t doneAt[int];

    int          respDelay = 1;
    mem_status_e respKind  = DMEM_DONE;
    logic [31:0] respData  = '0;

    int passCount  = 0;
    int checkCount = 0;
    bit checkOn    = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit port, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 1'b0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // A request visible in idle cycle s issues at s+1, occupies the memory for
    // the response delay (capped at TO) and completes the cycle after that.
    task automatic expectTxn(input int s, input bit port, input bit we,
                             input logic [31:0] addr, input logic [31:0] wdata, input int dropAt);
        txn_t t;
        int len, lastC;
        bit err;
        logic [31:0] rd;
        t = '{port, we, addr, wdata};
        if (respDelay == 0 || respDelay > TO) begin
            len = TO; err = 1'b1; rd = '0;
        end else begin
            len = respDelay;
            err = (respKind == DMEM_ERROR);
            rd  = err ? 32'h0 : respData;
        end
        issueAt[s + 1] = t;
        lastC = (dropAt > 0) ? dropAt : s + 1 + len;
        for (int c = s + 1; c <= lastC; c++) busyAt[c] = t;
        if (dropAt == 0) doneAt[s + 2 + len] = '{port, err, rd};
    endtask

    int  busyCnt = 0;
    bit  respActive = 0;
    initial begin
        mem_status = DMEM_IDLE;
        mem_r_data = 32'h1BAD1BAD;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin busyCnt = 0; respActive = 1; end
            @(posedge clk); #1;
            mem_r_data = 32'h1BAD1BAD;
            if (respActive) begin
                busyCnt++;
                if (respDelay != 0 && busyCnt == respDelay) begin
                    mem_status = respKind;
                    if (respKind == DMEM_DONE) mem_r_data = respData;
                    respActive = 0;
                end else begin
                    mem_status = DMEM_BUSY;
                end
            end else begin
                mem_status = DMEM_IDLE;
            end
        end
    end

    logic [31:0] heldR[2] = '{32'h0, 32'h0};
    bit    prevRst = 0;
    txn_t  cmpT;
    resp_t cmpR;
    bit    expD0, expD1;
    initial begin
        forever begin
            @(negedge clk);
            if (prevRst) heldR = '{32'h0, 32'h0};
            if (checkOn) begin
                expD0 = 0; expD1 = 0;
                if (doneAt.exists(cyc)) begin
                    cmpR = doneAt[cyc];
                    heldR[cmpR.port] = cmpR.rdata;
                    if (cmpR.port) expD1 = 1; else expD0 = 1;
                end
                checkOutput("mem_req", mem_req, issueAt.exists(cyc) ? 1 : 0);
                if (busyAt.exists(cyc)) begin
                    cmpT = busyAt[cyc];
                    checkOutput("mem_addr", mem_addr, cmpT.addr);
                    checkOutput("mem_w_data", mem_w_data, cmpT.wdata);
                    checkOutput("mem_we", mem_write_enabled, cmpT.we);
                end
                checkOutput("p0_done", p0_done, expD0);
                checkOutput("p1_done", p1_done, expD1);
                if (expD0) checkOutput("p0_err", p0_err, cmpR.err);
                if (expD1) checkOutput("p1_err", p1_err, cmpR.err);
                checkOutput("p0_rdata", p0_rdata, heldR[0]);
                checkOutput("p1_rdata", p1_rdata, heldR[1]);
                checkOutput("stall_m", stall_m, (p0_req && !expD0) ? 1 : 0);
            end
            prevRst = rst;
        end
    end

    bit order[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    int t;

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        step(2);
        @(negedge clk);
        checkOutput("rst mem_req", mem_req, 0);
        checkOutput("rst mem_addr", mem_addr, 0);
        checkOutput("rst mem_we", mem_write_enabled, 0);
        checkOutput("rst p0_done", p0_done, 0);
        checkOutput("rst p1_done", p1_done, 0);
        checkOutput("rst p0_rdata", p0_rdata, 0);
        checkOutput("rst stall_m", stall_m, 0);
        step(1);
        rst = 1'b0;
        checkOn = 1;
        step(1);

        // pipeline read; address/we changed after latch must not leak through
        t = cyc; respDelay = 1; respKind = DMEM_DONE; respData = 32'hDEADBEEF;
        applyStimulus(0, 1, 0, 32'h10, 32'h0);
        expectTxn(t, 0, 0, 32'h10, 32'h0, 0);
        step(1);
        p0_addr = 32'h999; p0_we = 1'b1;
        step(2);
        @(negedge clk);
        checkOutput("t1 p0_done", p0_done, 1);
        checkOutput("t1 p0_rdata", p0_rdata, 32'hDEADBEEF);
        checkOutput("t1 p0_err", p0_err, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0);
        step(1);

        // debug write
        t = cyc; respData = 32'h77777777;
        applyStimulus(1, 1, 1, 32'h20, 32'h12345678);
        expectTxn(t, 1, 1, 32'h20, 32'h12345678, 0);
        step(3);
        @(negedge clk);
        checkOutput("t2 p1_done", p1_done, 1);
        checkOutput("t2 p1_err", p1_err, 0);
        checkOutput("t2 p0_rdata", p0_rdata, 32'hDEADBEEF);
        step(1);
        applyStimulus(1, 0, 0, 0, 0);
        step(1);

        // both ports requesting back to back
        t = cyc; respData = 32'h55AA55AA;
        applyStimulus(0, 1, 0, 32'h100, 32'h0);
        applyStimulus(1, 1, 1, 32'h200, 32'hABCD);
        for (int n = 0; n < 10; n++)
            expectTxn(t + 4 * n, order[n], order[n], order[n] ? 32'h200 : 32'h100,
                      order[n] ? 32'hABCD : 32'h0, 0);
        step(19);
        @(negedge clk);
        checkOutput("t3 fifth grant p1", p1_done, 1);
        step(21);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);
        step(1);

        // memory stuck busy
        t = cyc; respDelay = 0;
        applyStimulus(0, 1, 0, 32'h30, 32'h0);
        expectTxn(t, 0, 0, 32'h30, 32'h0, 0);
        step(10);
        @(negedge clk);
        checkOutput("t4 p0_done", p0_done, 1);
        checkOutput("t4 p0_err", p0_err, 1);
        checkOutput("t4 p0_rdata", p0_rdata, 0);
        step(1);
        applyStimulus(0, 0, 0, 0, 0);
        step(1);

        // memory error
        t = cyc; respDelay = 2; respKind = DMEM_ERROR;
        applyStimulus(1, 1, 0, 32'h40, 32'h0);
        expectTxn(t, 1, 0, 32'h40, 32'h0, 0);
        step(4);
        @(negedge clk);
        checkOutput("t5 p1_err", p1_err, 1);
        checkOutput("t5 p1_rdata", p1_rdata, 0);
        step(1);
        applyStimulus(1, 0, 0, 0, 0);
        step(1);

        // completion in the same cycle the timeout is reached
        t = cyc; respDelay = TO; respKind = DMEM_DONE; respData = 32'h0BADF00D;
        applyStimulus(0, 1, 0, 32'h44, 32'h0);
        expectTxn(t, 0, 0, 32'h44, 32'h0, 0);
        step(10);
        @(negedge clk);
        checkOutput("t6 p0_err", p0_err, 0);
        checkOutput("t6 p0_rdata", p0_rdata, 32'h0BADF00D);
        step(1);
        applyStimulus(0, 0, 0, 0, 0);
        step(1);

        // reset while busy, request held through it
        t = cyc; respDelay = 5; respData = 32'h600DCAFE;
        applyStimulus(0, 1, 0, 32'h50, 32'h0);
        expectTxn(t, 0, 0, 32'h50, 32'h0, t + 3);
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        expectTxn(t + 4, 0, 0, 32'h50, 32'h0, 0);
        @(negedge clk);
        checkOutput("t7 mem_req", mem_req, 0);
        checkOutput("t7 mem_addr", mem_addr, 0);
        checkOutput("t7 mem_we", mem_write_enabled, 0);
        checkOutput("t7 p0_done", p0_done, 0);
        checkOutput("t7 p0_rdata", p0_rdata, 0);
        step(7);
        @(negedge clk);
        checkOutput("t7 p0_done after", p0_done, 1);
        checkOutput("t7 p0_rdata after", p0_rdata, 32'h600DCAFE);
        step(1);
        applyStimulus(0, 0, 0, 0, 0);
        step(3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data memory port between two requesters: port 0 = pipeline memory stage, port 1 = debug/loader port.
- Registers the winning request and drives the memory for exactly one transaction at a time.
- Waits for the memory's completion status, then returns read data and a done/error pulse to the owner.
- Produces the pipeline stall signal while a port-0 access is outstanding. Sits between the memory stage and DataMemory.

Parameters:
- TIMEOUT, 255: maximum cycles in BUSY before the transaction is aborted with error; must be ≥ 1.
- STARVE_LIMIT, 4: consecutive port-0 grants made while port 1 was requesting, after which port 1 wins the next arbitration; must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- p0_req  in  1  pipeline request; held until p0_done
- p0_we  in  1  pipeline write enable
- p0_addr  in  32  pipeline byte address
- p0_wdata  in  32  pipeline write data
- p0_rdata  out  32  read data returned to the pipeline
- p0_done  out  1  one-cycle completion pulse to the pipeline
- p0_err  out  1  error qualifier, valid with p0_done
- p1_req, p1_we, p1_addr, p1_wdata, p1_rdata, p1_done, p1_err  same as p0_*, for the debug port
- stall_m  out  1  freezes the pipeline while port 0 is waiting
- mem_write_enabled  out  1  to DataMemory
- mem_req  out  1  one-cycle start strobe to DataMemory
- mem_addr  out  32  to DataMemory
- mem_w_data  out  32  to DataMemory
- mem_r_data  in  32  from DataMemory
- mem_status  in  2  from DataMemory: 00 IDLE, 01 BUSY, 10 DONE, 11 ERROR

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous, active-high (rst).
- Reset values: all outputs 0, FSM in IDLE, starve and timeout counters 0.
- Reset mid-transaction: the transaction is dropped and no done pulse is issued.
- FSM states: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req is high, pick the winner, latch owner, we, addr and wdata, and go to ISSUE.
  - Default winner is port 0.
  - Port 1 wins when p1_req is high and either p0_req is low or starve_cnt == STARVE_LIMIT.
- Starve counter:
  - Increments on each port-0 grant made while p1_req is high.
  - Clears on any port-1 grant, and on any port-0 grant made while p1_req is low.
  - Saturates at STARVE_LIMIT.
- ISSUE (exactly 1 cycle):
  - mem_req = 1.
  - mem_write_enabled = latched we.
  - mem_addr and mem_w_data = latched values.
  - Next state BUSY; timeout counter cleared.
- BUSY:
  - mem_addr, mem_w_data and mem_write_enabled held; mem_req = 0.
  - mem_status == DONE: capture mem_r_data (on writes too) and go to RESP with err = 0.
  - mem_status == ERROR: go to RESP with err = 1 and rdata = 0.
  - Timeout: the counter increments each BUSY cycle; when it reaches TIMEOUT with no DONE/ERROR, go to RESP with err = 1 and rdata = 0.
  - DONE/ERROR seen in the same cycle the counter reaches TIMEOUT: status wins.
  - IDLE/BUSY status: stay.
- RESP (exactly 1 cycle):
  - Owner's done = 1; owner's err and rdata valid.
  - rdata is held stable until that port's next done.
  - Next state IDLE. No new arbitration in RESP, so there is a minimum 1-cycle IDLE gap between transactions.
- Minimum latency, req high to done pulse: IDLE (sample) → ISSUE → BUSY → RESP gives done 3 cycles after req is first sampled, when DONE arrives in the first BUSY cycle.
- stall_m: combinational; 1 when p0_req is high and not (FSM in RESP with owner = 0). It stays high during a port-1 transaction if p0_req is pending.
- Requester rules:
  - A requester must deassert req the cycle after its done.
  - A req that stays high is treated as a new request.
  - Changing addr/wdata/we while req is high has no effect after the request is latched.
- Simultaneous p0_req and p1_req: resolved by the starve rule above; the loser waits with its req held.
- mem_status outside BUSY is ignored.

Decomposition:
- Shared package dmem_pkg:
  - mem_status enum: DMEM_IDLE, DMEM_BUSY, DMEM_DONE, DMEM_ERROR.
  - arbiter state enum.
  - Owner encoding: OWN_PIPE = 0, OWN_DBG = 1.
- One sub-module, dmem_arb_select: combinational winner selection plus the saturating starve counter register.
- FSM, latches and timeout counter stay in dmem_arbiter.

Test Plan:
- p0 read addr 0x10, memory DONE 1 cycle after mem_req with r_data 0xDEADBEEF → p0_done 3 cycles after req, p0_rdata = 0xDEADBEEF, p0_err = 0; stall_m high from req until the done cycle.
- p1 write addr 0x20 data 0x12345678 → exactly one mem_req pulse with mem_write_enabled = 1 and the given addr/data; p1_done with p1_err = 0; p0 outputs unchanged.
- p0 and p1 requesting continuously, STARVE_LIMIT = 4 → grant order 0,0,0,0,1,0,0,0,0,1.
- mem_status stuck BUSY, TIMEOUT = 8 → p0_done with p0_err = 1 and p0_rdata = 0 after 8 BUSY cycles; next request is accepted normally.
- mem_status = ERROR in BUSY → done with err = 1; DONE asserted in the same cycle the timeout is reached → err = 0 (status wins).
- rst asserted while in BUSY → next cycle all outputs 0, FSM IDLE, no done pulse; p0_req held high → new transaction starts after rst drops.
